// File: rtl/adc_decimator_pkg.sv
// Shared constants and width helpers for the ADC front end and the convolution stage.
// Pure compile-time content: no logic and no latency.
// No flow control: widths and shifts only.
package adc_decimator_pkg;

  // Raw ADC sample width and conditioned output sample width
  localparam int ADC_W = 12;
  localparam int OUT_W = 16;

  // Extreme signed codes after format conversion (overrange markers)
  localparam logic signed [ADC_W-1:0] ADC_MAX = 12'sh7FF;
  localparam logic signed [ADC_W-1:0] ADC_MIN = 12'sh800;

  // Ceiling log2, used for constant width derivations only
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Boxcar accumulator width: one ADC word plus growth for DEC terms
  function automatic int sum_w(input int dec);
    return ADC_W + clog2(dec);
  endfunction

  // Left shift that places the accumulator MSB at the output MSB
  function automatic int out_shift(input int dec);
    return OUT_W - sum_w(dec);
  endfunction

endpackage

// File: rtl/adc_decimator_dec_channel.sv
// One decimation channel: format conversion, boxcar accumulator, scaling, overrange flag.
// Output data registered 1 cycle after the sample flagged i_last.
// No backpressure: every i_smp_vld sample is consumed in its cycle.
module dec_channel
  import adc_decimator_pkg::*;
#(
  parameter int DEC        = 5,
  parameter bit OFFSET_BIN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_smp_vld,
  input  logic              i_first,
  input  logic              i_last,
  input  logic              i_flush,
  input  logic              i_ovr_clr,
  input  logic [ADC_W-1:0]  i_adc,
  output logic [OUT_W-1:0]  o_dat,
  output logic              o_ovr
);

  localparam int SW = sum_w(DEC);
  localparam int SH = out_shift(DEC);

  logic signed [ADC_W-1:0] w_smp;
  logic signed [SW-1:0]    w_smp_ext;
  logic signed [SW-1:0]    w_sum;
  logic signed [OUT_W-1:0] w_sum16;
  logic signed [OUT_W-1:0] w_scaled;
  logic                    w_ovr_hit;

  logic signed [SW-1:0]    r_acc;
  logic [OUT_W-1:0]        r_dat;
  logic                    r_ovr;

  // Offset binary becomes two's complement by flipping the MSB
  assign w_smp     = OFFSET_BIN ? {~i_adc[ADC_W-1], i_adc[ADC_W-2:0]} : i_adc;
  assign w_smp_ext = SW'(w_smp);

  // Phase 0 starts a fresh sum, so a discarded partial sum never leaks in
  assign w_sum     = i_first ? w_smp_ext : (r_acc + w_smp_ext);

  // Sign-extend to the output width, then left-justify
  assign w_sum16   = OUT_W'(w_sum);
  assign w_scaled  = w_sum16 <<< SH;

  assign w_ovr_hit = i_smp_vld && ((w_smp == ADC_MAX) || (w_smp == ADC_MIN));

  // Accumulator: an accepted sample wins over a flush in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_smp_vld) begin
      r_acc <= w_sum;
    end else if (i_flush) begin
      r_acc <= '0;
    end
  end

  // Output word only moves on the closing sample of a decimation period
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dat <= '0;
    end else if (i_smp_vld && i_last) begin
      r_dat <= w_scaled;
    end
  end

  // Sticky overrange flag; a new hit beats a simultaneous clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovr <= 1'b0;
    end else if (w_ovr_hit) begin
      r_ovr <= 1'b1;
    end else if (i_ovr_clr) begin
      r_ovr <= 1'b0;
    end
  end

  assign o_dat = r_dat;
  assign o_ovr = r_ovr;

endmodule

// File: rtl/adc_decimator.sv
// Two-channel ADC boxcar decimator with phase sync, overrange flags and gap watchdog.
// data_out_en and data registered 1 cycle after the DEC-th accepted adc_en.
// No backpressure: consumer must accept every data_out_en strobe.
module adc_decimator
  import adc_decimator_pkg::*;
#(
  parameter int DEC        = 5,      // legal range 2..16
  parameter bit OFFSET_BIN = 1'b1,
  parameter int GAP_MAX    = 20
) (
  input  logic              clkf,
  input  logic              rst,
  input  logic              enable,
  input  logic              sync,
  input  logic              adc_en,
  input  logic [ADC_W-1:0]  ADC_A,
  input  logic [ADC_W-1:0]  ADC_B,
  input  logic              ovr_clr,
  output logic              data_out_en,
  output logic [OUT_W-1:0]  DATA_OUT_A,
  output logic [OUT_W-1:0]  DATA_OUT_B,
  output logic              OVR_A,
  output logic              OVR_B,
  output logic [15:0]       GAP_CNT
);

  localparam logic [3:0]  PH_LAST = 4'(DEC - 1);
  localparam logic [15:0] GAP_LIM = 16'(GAP_MAX);

  logic [3:0]  r_ph;
  logic [15:0] r_gap;
  logic [15:0] r_gap_cnt;
  logic        r_out_en;

  logic        w_accept;
  logic        w_wd_fire;
  logic [3:0]  w_ph_cur;
  logic        w_first;
  logic        w_last;
  logic        w_flush;

  assign w_accept  = enable && adc_en;

  // Watchdog only matters when a partial sum exists; a real sample wins
  assign w_wd_fire = enable && !w_accept && (r_gap == GAP_LIM) && (r_ph != 4'd0);

  // sync makes the coincident sample phase 0
  assign w_ph_cur  = sync ? 4'd0 : r_ph;
  assign w_first   = (w_ph_cur == 4'd0);
  assign w_last    = (w_ph_cur == PH_LAST);

  // Discard the partial sum when no sample arrives to restart it
  assign w_flush   = !w_accept && (sync || w_wd_fire || !enable);

  // Phase counter: advance per accepted sample, wrap on the closing one
  always_ff @(posedge clkf) begin
    if (rst) begin
      r_ph <= 4'd0;
    end else if (w_accept) begin
      r_ph <= w_last ? 4'd0 : (w_ph_cur + 4'd1);
    end else if (w_flush) begin
      r_ph <= 4'd0;
    end
  end

  // Cycles since last accepted sample, saturating; held at zero while disabled
  always_ff @(posedge clkf) begin
    if (rst) begin
      r_gap <= 16'd0;
    end else if (!enable || w_accept) begin
      r_gap <= 16'd0;
    end else if (r_gap != GAP_LIM) begin
      r_gap <= r_gap + 16'd1;
    end
  end

  // Saturating count of watchdog-forced resyncs
  always_ff @(posedge clkf) begin
    if (rst) begin
      r_gap_cnt <= 16'd0;
    end else if (w_wd_fire && (r_gap_cnt != 16'hFFFF)) begin
      r_gap_cnt <= r_gap_cnt + 16'd1;
    end
  end

  // Output strobe one cycle after the closing sample; at most every other cycle since DEC >= 2
  always_ff @(posedge clkf) begin
    if (rst) begin
      r_out_en <= 1'b0;
    end else begin
      r_out_en <= w_accept && w_last;
    end
  end

  dec_channel #(
    .DEC        (DEC),
    .OFFSET_BIN (OFFSET_BIN)
  ) u_ch_a (
    .i_clk     (clkf),
    .i_rst     (rst),
    .i_smp_vld (w_accept),
    .i_first   (w_first),
    .i_last    (w_last),
    .i_flush   (w_flush),
    .i_ovr_clr (ovr_clr),
    .i_adc     (ADC_A),
    .o_dat     (DATA_OUT_A),
    .o_ovr     (OVR_A)
  );

  dec_channel #(
    .DEC        (DEC),
    .OFFSET_BIN (OFFSET_BIN)
  ) u_ch_b (
    .i_clk     (clkf),
    .i_rst     (rst),
    .i_smp_vld (w_accept),
    .i_first   (w_first),
    .i_last    (w_last),
    .i_flush   (w_flush),
    .i_ovr_clr (ovr_clr),
    .i_adc     (ADC_B),
    .o_dat     (DATA_OUT_B),
    .o_ovr     (OVR_B)
  );

  assign data_out_en = r_out_en;
  assign GAP_CNT     = r_gap_cnt;

endmodule

// File: tb/tb_adc_decimator.sv
// Directed bench for adc_decimator: three configurations share one stimulus stream.
// u0: DEC=5 two's complement, u1: DEC=5 offset binary, u2: DEC=2 two's complement.
// Expected values are hand-computed constants.
module tb_adc_decimator;

  logic clkf = 1'b0;
  always #10 clkf = ~clkf;

  logic        rst, enable, sync, adc_en, ovr_clr;
  logic [11:0] ADC_A, ADC_B;

  logic        en0, en1, en2;
  logic [15:0] a0, b0, a1, b1, a2, b2;
  logic [15:0] gc0, gc1, gc2;
  logic        oa0, ob0, oa1, ob1, oa2, ob2;

  int n_chk  = 0;
  int n_pass = 0;
  int n_str0 = 0;
  int n_str1 = 0;
  int n_str2 = 0;
  int s;
  logic e0, e1;

  adc_decimator #(.DEC(5), .OFFSET_BIN(1'b0), .GAP_MAX(20)) u0 (
    .clkf(clkf), .rst(rst), .enable(enable), .sync(sync), .adc_en(adc_en),
    .ADC_A(ADC_A), .ADC_B(ADC_B), .ovr_clr(ovr_clr), .data_out_en(en0),
    .DATA_OUT_A(a0), .DATA_OUT_B(b0), .OVR_A(oa0), .OVR_B(ob0), .GAP_CNT(gc0)
  );

  adc_decimator #(.DEC(5), .OFFSET_BIN(1'b1), .GAP_MAX(20)) u1 (
    .clkf(clkf), .rst(rst), .enable(enable), .sync(sync), .adc_en(adc_en),
    .ADC_A(ADC_A), .ADC_B(ADC_B), .ovr_clr(ovr_clr), .data_out_en(en1),
    .DATA_OUT_A(a1), .DATA_OUT_B(b1), .OVR_A(oa1), .OVR_B(ob1), .GAP_CNT(gc1)
  );

  adc_decimator #(.DEC(2), .OFFSET_BIN(1'b0), .GAP_MAX(20)) u2 (
    .clkf(clkf), .rst(rst), .enable(enable), .sync(sync), .adc_en(adc_en),
    .ADC_A(ADC_A), .ADC_B(ADC_B), .ovr_clr(ovr_clr), .data_out_en(en2),
    .DATA_OUT_A(a2), .DATA_OUT_B(b2), .OVR_A(oa2), .OVR_B(ob2), .GAP_CNT(gc2)
  );

  // Strobe counters, sampled mid-cycle
  always @(negedge clkf) begin
    if (en0) n_str0++;
    if (en1) n_str1++;
    if (en2) n_str2++;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clkf);
    #1;
  endtask

  // One sample pair, strobe state captured right after the accepting edge, then idle
  task automatic smp(input logic [11:0] a, input logic [11:0] b, input int gap,
                     output logic s0, output logic s1);
    ADC_A  = a;
    ADC_B  = b;
    adc_en = 1'b1;
    tick();
    s0 = en0;
    s1 = en1;
    adc_en  = 1'b0;
    sync    = 1'b0;
    ovr_clr = 1'b0;
    repeat (gap - 1) tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; sync = 1'b0; adc_en = 1'b0; ovr_clr = 1'b0;
    ADC_A = 12'h000; ADC_B = 12'h000;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_en", en0, 0);
    chk("rst_a", $signed(a0), 0);
    chk("rst_b", $signed(b0), 0);
    chk("rst_ovr", oa0, 0);
    chk("rst_gap", gc0, 0);

    // Constant input: +100 / -100, five samples
    s = n_str0;
    for (int i = 0; i < 5; i++) begin
      smp(12'd100, 12'hF9C, 10, e0, e1);
      if (i == 3) chk("const_early", e0, 0);
    end
    chk("const_lat", e0, 1);
    chk("const_a", $signed(a0), 1000);
    chk("const_b", $signed(b0), -1000);
    chk("const_nstr", n_str0 - s, 1);

    // Offset binary extremes on u1
    for (int i = 0; i < 5; i++) smp(12'hFFF, 12'h800, 10, e0, e1);
    chk("ob_lat", e1, 1);
    chk("ob_a", $signed(a1), 20470);
    chk("ob_ovra", oa1, 1);
    chk("ob_ovrb", ob1, 0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    tick();
    chk("ovr_clr", oa1, 0);
    ovr_clr = 1'b1;
    smp(12'h000, 12'h800, 10, e0, e1);
    chk("ovr_set_wins", oa1, 1);
    for (int i = 0; i < 4; i++) smp(12'h000, 12'h800, 10, e0, e1);
    chk("ob_min", $signed(a1), -20480);
    chk("ob_bzero", $signed(b1), 0);

    // Sync realignment: the 10s are discarded
    s = n_str0;
    for (int i = 0; i < 3; i++) smp(12'd10, 12'd10, 10, e0, e1);
    sync = 1'b1;
    smp(12'd7, 12'd7, 10, e0, e1);
    for (int i = 0; i < 4; i++) smp(12'd7, 12'd7, 10, e0, e1);
    chk("sync_lat", e0, 1);
    chk("sync_a", $signed(a0), 70);
    chk("sync_nstr", n_str0 - s, 1);

    // Watchdog: two samples, then a long gap
    s = n_str0;
    for (int i = 0; i < 2; i++) smp(12'd5, 12'd5, 10, e0, e1);
    repeat (5) tick();
    chk("wd_before", gc0, 0);
    repeat (16) tick();
    chk("wd_cnt", gc0, 1);
    for (int i = 0; i < 5; i++) smp(12'd1, 12'd1, 10, e0, e1);
    chk("wd_out", $signed(a0), 10);
    chk("wd_nstr", n_str0 - s, 1);

    // Enable toggle: partial sum flushed, strobes while disabled ignored
    s = n_str0;
    for (int i = 0; i < 3; i++) smp(12'hFFF, 12'hFFF, 10, e0, e1);
    enable = 1'b0;
    smp(12'hFFF, 12'hFFF, 3, e0, e1);
    chk("en_hold", $signed(a0), 10);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) smp(12'hFFF, 12'h001, 10, e0, e1);
    chk("en_a", $signed(a0), -10);
    chk("en_b", $signed(b0), 10);
    chk("en_nstr", n_str0 - s, 1);

    // Reset mid-accumulation
    chk("ovrb_pre", ob0, 1);
    s = n_str0;
    for (int i = 0; i < 4; i++) smp(12'd3, 12'd3, 10, e0, e1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_a", $signed(a0), 0);
    chk("mrst_b", $signed(b0), 0);
    chk("mrst_ovrb", ob0, 0);
    chk("mrst_gap", gc0, 0);
    tick();
    chk("mrst_en", en0, 0);
    chk("mrst_nstr", n_str0 - s, 0);
    s = n_str0;
    for (int i = 0; i < 5; i++) smp(12'd3, 12'd3, 10, e0, e1);
    chk("post_rst_a", $signed(a0), 30);
    chk("post_rst_nstr", n_str0 - s, 1);

    // DEC=2 with back-to-back strobes
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ADC_A  = 12'h001;
    ADC_B  = 12'hFFF;
    adc_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("d2_en%0d", i), en2, i % 2);
    end
    adc_en = 1'b0;
    tick();
    chk("d2_idle_en", en2, 0);
    chk("d2_a", $signed(a2), 16);
    chk("d2_b", $signed(b2), -16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
